// File: rtl/uart_rx_frontend.sv
// Oversampling UART receiver: free-running 16x baud tick, two-flop rx synchroniser
// and a start/data/stop FSM that reports each byte with a one-cycle strobe.
module uart_rx_frontend #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 163
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);
    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);
    localparam logic [SW-1:0] S_MID     = SW'(7);
    localparam logic [SW-1:0] S_BIT     = SW'(15);
    localparam logic [SW-1:0] S_STOP    = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_n;
    logic [TW-1:0]   baud_cnt;
    logic            tick;
    logic            rx_sync_p0, rx_sync_p1;
    logic            rx_s;
    logic [SW-1:0]   s_q, s_n;
    logic [NW-1:0]   n_q, n_n;
    logic [DBIT-1:0] b_q, b_n;
    logic [DBIT-1:0] data_n;
    logic            ferr_n;
    logic            done_n;

    // Baud tick: free-running, never realigned to the frame
    assign tick = (baud_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt <= '0;
        end else if (tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + TW'(1);
        end
    end

    // Input synchroniser: flops reset to the idle-high line level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    assign rx_s = rx_sync_p1;

    // Frame FSM: next state, counters, shift register and output loads
    always_comb begin
        state_n = state_q;
        s_n     = s_q;
        n_n     = n_q;
        b_n     = b_q;
        data_n  = rx_data;
        ferr_n  = frame_err;
        done_n  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_BIT) begin
                        s_n = '0;
                        b_n = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_n = STOP;
                        end else begin
                            n_n = n_q + NW'(1);
                        end
                    end else begin
                        s_n = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_STOP) begin
                        state_n = IDLE;
                        data_n  = b_q;
                        ferr_n  = ~rx_s;
                        done_n  = 1'b1;
                    end else begin
                        s_n = s_q + SW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; busy is registered alongside it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_n;
            busy    <= (state_n != IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            rx_data      <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            s_q          <= s_n;
            n_q          <= n_n;
            b_q          <= b_n;
            rx_data      <= data_n;
            frame_err    <= ferr_n;
            rx_done_tick <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend: a fast instance (BAUD_DIV=4) under directed
// and random frames, plus a default-parameter instance for the 19200-baud latency case.
module tb_uart_rx_frontend;
    localparam int BD    = 4;
    localparam int BIT   = 16 * BD;
    localparam int BD_D  = 163;
    localparam int BIT_D = 16 * BD_D;
    localparam int CLK_P = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       rx_d;
    logic [7:0] rx_data, rx_data_d;
    logic       rx_done_tick, frame_err, busy;
    logic       done_d, ferr_d, busy_d;

    always #(CLK_P / 2) clk = ~clk;

    uart_rx_frontend #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(BD)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    uart_rx_frontend dut_d (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx_d),
        .rx_data      (rx_data_d),
        .rx_done_tick (done_d),
        .frame_err    (ferr_d),
        .busy         (busy_d)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         strobes  = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_q_d[$];
    logic       prev_done = 1'b0;
    longint     t_fall_d = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor for the fast instance: pop expected {frame_err, byte} on each strobe
    always @(negedge clk) begin
        logic [8:0] e;
        if (reset_n === 1'b1 && rx_done_tick === 1'b1) begin
            strobes++;
            check("strobe_width", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: got data %0h, expected no strobe", rx_data);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(e[7:0]));
                check("frame_err", 32'(frame_err), 32'(e[8]));
            end
        end
        prev_done = rx_done_tick;
    end

    // Monitor for the default instance, including falling-edge-to-strobe latency
    always @(negedge clk) begin
        logic [8:0] e;
        longint     lat;
        if (reset_n === 1'b1 && done_d === 1'b1) begin
            if (exp_q_d.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe_d: got data %0h, expected no strobe", rx_data_d);
            end else begin
                e = exp_q_d.pop_front();
                check("rx_data_d", 32'(rx_data_d), 32'(e[7:0]));
                check("frame_err_d", 32'(ferr_d), 32'(e[8]));
                lat = ($time - t_fall_d) / CLK_P;
                n_checks++;
                if (lat >= 9 * BIT_D && lat <= (BIT_D * 19) / 2 + 165) n_pass++;
                else $display("FAIL latency_d: got %0d clocks, expected %0d..%0d",
                              lat, 9 * BIT_D, (BIT_D * 19) / 2 + 165);
            end
        end
    end

    task automatic hold(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic hold_d(input logic v, input int cycles);
        rx_d = v;
        repeat (cycles) @(negedge clk);
    endtask

    // A bad stop bit is pulled low just past its sampling point, then released
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        exp_q.push_back({~stop_ok, d});
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
        if (stop_ok) begin
            hold(1'b1, BIT);
        end else begin
            hold(1'b0, BIT / 2 + 12);
            hold(1'b1, BIT / 2 - 12);
            hold(1'b1, 2 * BIT);
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || exp_q_d.size() != 0) && k < 4 * BIT_D) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (exp_q.size() == 0 && exp_q_d.size() == 0) n_pass++;
        else begin
            $display("FAIL %s: got %0d frames pending, expected 0", name,
                     exp_q.size() + exp_q_d.size());
            exp_q.delete();
            exp_q_d.delete();
        end
    endtask

    initial begin
        #(50_000_000);
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        logic [7:0] d;
        logic       ok;
        reset_n = 1'b0;
        rx      = 1'b1;
        rx_d    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_done", 32'(rx_done_tick), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        hold(1'b1, 2 * BIT);

        s0 = strobes;
        send_frame(8'h55, 1'b1);
        hold(1'b1, BIT);
        drain("drain_55");
        check("strobes_55", 32'(strobes - s0), 32'd1);
        check("busy_after_55", 32'(busy), 32'd0);

        s0 = strobes;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        hold(1'b1, BIT);
        drain("drain_b2b");
        check("strobes_b2b", 32'(strobes - s0), 32'd2);
        check("hold_0f", 32'(rx_data), 32'h0F);

        s0 = strobes;
        hold(1'b0, 5 * BD);
        hold(1'b1, 2 * BIT);
        check("glitch_strobes", 32'(strobes - s0), 32'd0);
        check("glitch_busy", 32'(busy), 32'd0);
        send_frame(8'h3C, 1'b1);
        hold(1'b1, BIT);
        drain("drain_3c");

        send_frame(8'h81, 1'b0);
        drain("drain_81");
        send_frame(8'h7E, 1'b1);
        hold(1'b1, BIT);
        drain("drain_7e");
        check("ferr_cleared", 32'(frame_err), 32'd0);

        // Reset in the middle of data bit 4 of 0xFF, after a bad frame
        send_frame(8'hC5, 1'b0);
        drain("drain_c5");
        s0 = strobes;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(1'b1, BIT);
        hold(1'b1, BIT / 2);
        check("busy_mid_frame", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(rx_done_tick), 32'd0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        hold(1'b1, 2 * BIT);
        check("rst_no_strobe", 32'(strobes - s0), 32'd0);
        send_frame(8'h12, 1'b1);
        hold(1'b1, BIT);
        drain("drain_12");

        for (int f = 0; f < 14; f++) begin
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            send_frame(d, ok);
            if (ok) hold(1'b1, $urandom_range(0, 2) * BIT);
        end
        hold(1'b1, BIT);
        drain("drain_random");
        check("busy_after_random", 32'(busy), 32'd0);

        exp_q_d.push_back({1'b0, 8'h67});
        t_fall_d = $time;
        hold_d(1'b0, BIT_D);
        for (int i = 0; i < 8; i++) hold_d(d_bit(8'h67, i), BIT_D);
        hold_d(1'b1, BIT_D);
        drain("drain_67");
        check("busy_d_after", 32'(busy_d), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    function automatic logic d_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
